// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and helpers for the seg_scan_mux display driver.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
// Contents: FSM state encoding, output active level, index-width helper.
package seg_scan_pkg;

    // IDLE: display dark; SHOW: one digit lit; BLANK: anti-ghost gap between digits.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    // Active level of both segment and digit-enable pins.
    localparam logic ACT_LVL = 1'b1;

    // Width of an index able to address n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: pattern/control inputs and display outputs of seg_scan_mux.
// Latency: n/a (wiring bundle).
// Backpressure: none; the display path is free-running.
// Ports: DATA/EN_MASK/MANUAL/SEL from the decoders, SEG_OUT/DIG_OUT/CH_IDX/TICK to the pins.
interface seg_scan_mux_if
    import seg_scan_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEG_W    = 7,
    parameter int IDX_W    = idx_w(CHANNELS)
);
    logic [CHANNELS*SEG_W-1:0] DATA;
    logic [CHANNELS-1:0]       EN_MASK;
    logic                      MANUAL;
    logic [IDX_W-1:0]          SEL;
    logic [SEG_W-1:0]          SEG_OUT;
    logic [CHANNELS-1:0]       DIG_OUT;
    logic [IDX_W-1:0]          CH_IDX;
    logic                      TICK;

    // Upstream side: supplies patterns and mode control, observes the display.
    modport master (
        output DATA, EN_MASK, MANUAL, SEL,
        input  SEG_OUT, DIG_OUT, CH_IDX, TICK
    );

    // Driver side: the scan multiplexer itself.
    modport slave (
        input  DATA, EN_MASK, MANUAL, SEL,
        output SEG_OUT, DIG_OUT, CH_IDX, TICK
    );
endinterface

// File: rtl/seg_next_ch.sv
// seg_next_ch: finds the next enabled channel above cur_idx_i, wrapping around.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: cur_idx_i/en_mask_i in; nxt_idx_o, vld_o (any channel enabled) out.
module seg_next_ch
    import seg_scan_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int IDX_W    = idx_w(CHANNELS)
) (
    input  logic [IDX_W-1:0]    cur_idx_i,
    input  logic [CHANNELS-1:0] en_mask_i,
    output logic [IDX_W-1:0]    nxt_idx_o,
    output logic                vld_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Rotated priority search: offsets 1..CHANNELS so the last candidate is the
    // current index itself, which makes a lone enabled channel hold. An index left
    // out of range by manual mode still lands on a valid channel via the modulo.
    always_comb begin
        nxt_idx_o = cur_idx_i;
        found     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = IDX_W'((int'(cur_idx_i) + i) % CHANNELS);
            if (!found && en_mask_i[cand]) begin
                found     = 1'b1;
                nxt_idx_o = cand;
            end
        end
    end

    assign vld_o = |en_mask_i;

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment driver scanning enabled channels per refresh tick.
// Latency: SEG_OUT/DIG_OUT registered, one cycle after CH_IDX or DATA changes.
// Backpressure: none; free-running display scan, manual mode holds one channel.
// Ports: CLK, RESET (sync, active-high), bus (seg_scan_mux_if.slave).
// Optional: define SEG_SCAN_BLANKING_EN to insert BLANK_CYCLES dark cycles on every channel change.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int SEG_W        = 7,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    seg_scan_mux_if.slave bus
);

    localparam int              IDX_W   = idx_w(CHANNELS);
    localparam int              PS_W    = idx_w(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    // Elaboration-time parameter sanity.
    if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
        $error("seg_scan_mux: CHANNELS must be in 2..16");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("seg_scan_mux: PRESCALE must be >= 2");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("seg_scan_mux: BLANK_CYCLES must be >= 1");
    end

    logic [PS_W-1:0]     presc_q,  presc_d;
    logic                tick_q,   tick_d;
    logic [IDX_W-1:0]    ch_idx_q, ch_idx_d;
    state_e              state_q,  state_d;
    logic [SEG_W-1:0]    seg_q,    seg_d;
    logic [CHANNELS-1:0] dig_q,    dig_d;

    logic                wrap;
    logic                adv;
    logic                any_en;
    logic [IDX_W-1:0]    nxt_idx;
    logic                show_ok;
    logic [SEG_W-1:0]    cur_seg;
    logic [CHANNELS-1:0] cur_dig;

`ifdef SEG_SCAN_BLANKING_EN
    localparam int              BC_W    = idx_w(BLANK_CYCLES);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLANK_CYCLES - 1);
    if (BLANK_CYCLES >= PRESCALE) begin : g_bad_blank_len
        $error("seg_scan_mux: BLANK_CYCLES must be < PRESCALE");
    end

    logic [BC_W-1:0] blank_cnt_q, blank_cnt_d;
    logic            pend_q, pend_d;
    logic            chg;
`endif

    // ------------------------------------------------------------------
    // Refresh prescaler; TICK is the registered wrap event.
    // ------------------------------------------------------------------
    assign wrap    = (presc_q == PS_LAST);
    assign presc_d = wrap ? '0 : presc_q + 1'b1;
    assign tick_d  = wrap;

    seg_next_ch #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_next_ch (
        .cur_idx_i (ch_idx_q),
        .en_mask_i (bus.EN_MASK),
        .nxt_idx_o (nxt_idx),
        .vld_o     (any_en)
    );

    // Decode the registered index against live DATA/EN_MASK. Compare-based
    // selection keeps an out-of-range manual index dark instead of indexing past
    // the end of the buses.
    always_comb begin
        show_ok = 1'b0;
        cur_seg = '0;
        cur_dig = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_idx_q == IDX_W'(i)) begin
                show_ok    = bus.EN_MASK[i];
                cur_seg    = bus.DATA[i*SEG_W +: SEG_W];
                cur_dig[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel index: SEL every cycle in manual, next enabled channel per tick in auto.
    // ------------------------------------------------------------------
`ifdef SEG_SCAN_BLANKING_EN
    // Ticks landing inside BLANK are parked in pend_q and taken once BLANK ends.
    assign adv = !bus.MANUAL && any_en && (wrap || pend_q) && (state_q != ST_BLANK);
`else
    assign adv = !bus.MANUAL && any_en && wrap;
`endif

    always_comb begin
        ch_idx_d = ch_idx_q;
        if (bus.MANUAL) begin
            ch_idx_d = bus.SEL;
        end else if (adv) begin
            ch_idx_d = nxt_idx;
        end
    end

    // ------------------------------------------------------------------
    // Display FSM and registered outputs.
    // ------------------------------------------------------------------
`ifdef SEG_SCAN_BLANKING_EN
    assign chg = (ch_idx_d != ch_idx_q);

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        pend_d      = pend_q;
        seg_d       = '0;
        dig_d       = '0;

        if (bus.MANUAL || adv) begin
            pend_d = 1'b0;
        end else if (wrap && state_q == ST_BLANK) begin
            pend_d = 1'b1;
        end

        if (chg) begin
            // Any index change, even mid-BLANK, restarts the full dark gap.
            state_d     = ST_BLANK;
            blank_cnt_d = BC_LAST;
        end else begin
            case (state_q)
                ST_IDLE:  if (show_ok)  state_d = ST_SHOW;
                ST_SHOW:  if (!show_ok) state_d = ST_IDLE;
                ST_BLANK: begin
                    if (blank_cnt_q == '0) begin
                        state_d = show_ok ? ST_SHOW : ST_IDLE;
                    end else begin
                        blank_cnt_d = blank_cnt_q - 1'b1;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end

        if (state_d == ST_SHOW) begin
            seg_d = cur_seg;
            dig_d = cur_dig;
        end
    end
`else
    always_comb begin
        state_d = state_q;
        seg_d   = '0;
        dig_d   = '0;

        case (state_q)
            ST_IDLE: if (show_ok)  state_d = ST_SHOW;
            ST_SHOW: if (!show_ok) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase

        if (state_d == ST_SHOW) begin
            seg_d = cur_seg;
            dig_d = cur_dig;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_q     <= '0;
            tick_q      <= 1'b0;
            ch_idx_q    <= '0;
            state_q     <= ST_IDLE;
            seg_q       <= '0;
            dig_q       <= '0;
`ifdef SEG_SCAN_BLANKING_EN
            blank_cnt_q <= '0;
            pend_q      <= 1'b0;
`endif
        end else begin
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            ch_idx_q    <= ch_idx_d;
            state_q     <= state_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
`ifdef SEG_SCAN_BLANKING_EN
            blank_cnt_q <= blank_cnt_d;
            pend_q      <= pend_d;
`endif
        end
    end

    // Internal state is active-high; map to pin polarity at the boundary.
    assign bus.SEG_OUT = seg_q ^ {SEG_W{~ACT_LVL}};
    assign bus.DIG_OUT = dig_q ^ {CHANNELS{~ACT_LVL}};
    assign bus.CH_IDX  = ch_idx_q;
    assign bus.TICK    = tick_q;

endmodule
